mux4_rr_arbiter: RTL and testbench

//  Round-robin arbiter that shares one 4:1 single-bit mux among four requesters.
//  It grants one requester at a time, drives the mux select `ss`, and enforces a maximum hold time.
//  A one-cycle dead turnaround separates every ownership change, so mux output never switches mid-grant.
//  It sits between the requester ports and the mux select, one instance per shared mux.

---
 rtl/mux4_rr_arbiter_pkg.sv | 31 +++
 rtl/mux4_rr_arbiter_if.sv | 39 +++
 rtl/mux4_rr_arbiter_rr_pick4.sv | 37 +++
 rtl/mux4_rr_arbiter.sv | 128 ++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/mux4_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter_pkg
//   Shared definitions for the 4:1 mux round-robin arbiter and future mux
//   controllers that reuse the same requester count and select width.
//   Contents:
//     NUM_REQ   number of requesters sharing one mux
//     SEL_W     width of the mux select
//     state_t   arbiter FSM state encoding (IDLE/OWN/TURN, 2'b11 illegal)
//     onehot4   select index -> one-hot grant vector
// ---------------------------------------------------------------------------
package mux4_rr_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  // 2'b11 is deliberately left unnamed; the FSM treats it as illegal and
  // recovers to IDLE with no grant.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN  = 2'b01,
    ST_TURN = 2'b10
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter_if
//   Requester/arbiter bundle for one shared 4:1 single-bit mux.
//   Signals:
//     req      level request per requester, held for the whole transfer
//     gnt      registered one-hot grant, all-zero when nobody owns the mux
//     ss       mux select = owner index, holds last value when gnt == 0
//     busy     high while an owner holds the mux
//     preempt  one-cycle pulse when an owner is cut off by the hold limit
//   Modports:
//     master   requester side (drives req, observes the rest)
//     slave    arbiter side (observes req, drives the rest)
// ---------------------------------------------------------------------------
interface mux4_rr_arbiter_if;
  import mux4_rr_arbiter_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [SEL_W-1:0]   ss;
  logic               busy;
  logic               preempt;

  modport master (
    output req,
    input  gnt,
    input  ss,
    input  busy,
    input  preempt
  );

  modport slave (
    input  req,
    output gnt,
    output ss,
    output busy,
    output preempt
  );

endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// ---------------------------------------------------------------------------
// rr_pick4
//   Combinational rotate-priority scan. Starting at ptr and moving upward
//   modulo 4, returns the first requester whose req bit is set.
//   Ports:
//     req  in   4  request vector
//     ptr  in   2  highest-priority index
//     any  out  1  at least one request present
//     idx  out  2  winning index (equals ptr when any == 0)
// ---------------------------------------------------------------------------
module rr_pick4
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               any,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0] cand;

  // Scan from the lowest-priority offset up to ptr itself so that the last
  // hit written is the one closest to ptr, i.e. the highest-priority winner.
  always_comb begin
    any  = 1'b0;
    idx  = ptr;
    cand = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter
//   Round-robin arbiter sharing one 4:1 single-bit mux among four requesters.
//   Grants one requester at a time, drives the mux select, limits how long
//   an owner may hold the mux while others wait, and inserts a one-cycle dead
//   turnaround (TURN) on every ownership change so the mux output never
//   switches mid-grant.
//   Parameters:
//     MAX_HOLD  max consecutive grant cycles while another req is pending;
//               0 = unlimited
//     CNT_W     hold counter width, must satisfy MAX_HOLD < 2**CNT_W
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset
//     bus    slave side of mux4_rr_arbiter_if (req in; gnt/ss/busy/preempt out)
// ---------------------------------------------------------------------------
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mux4_rr_arbiter_if.slave   bus
);

  if (MAX_HOLD < 0 || MAX_HOLD >= (1 << CNT_W)) begin : g_bad_cfg
    $error("mux4_rr_arbiter: MAX_HOLD must be in [0, 2**CNT_W)");
  end

  // With an unlimited hold the counter only needs to stop wrapping; it is
  // never compared against a limit.
  localparam logic [CNT_W-1:0] HOLD_CAP =
    (MAX_HOLD == 0) ? {CNT_W{1'b1}} : CNT_W'(MAX_HOLD);

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0]   ss_q, ss_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   hold_q, hold_d;
  logic               preempt_q, preempt_d;

  logic               pick_any;
  logic [SEL_W-1:0]   pick_idx;
  logic               owner_req;
  logic               others_wait;
  logic               hold_expired;

  rr_pick4 u_pick (
    .req (bus.req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  // In OWN the select register always names the owner.
  assign owner_req    = bus.req[ss_q];
  assign others_wait  = (bus.req & ~gnt_q) != '0;
  assign hold_expired = (MAX_HOLD != 0) && (hold_q == HOLD_CAP) && others_wait;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ss_d      = ss_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;

    case (state_q)
      // IDLE and TURN arbitrate identically; they differ only in where the
      // FSM came from. ss is left alone so the mux does not glitch.
      ST_IDLE, ST_TURN: begin
        gnt_d = '0;
        if (pick_any) begin
          state_d = ST_OWN;
          gnt_d   = onehot4(pick_idx);
          ss_d    = pick_idx;
          hold_d  = CNT_W'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_OWN: begin
        if (!owner_req || hold_expired) begin
          state_d   = ST_TURN;
          gnt_d     = '0;
          ptr_d     = ss_q + SEL_W'(1);
          // A voluntary release on the same edge is not a preemption.
          preempt_d = owner_req;
        end else if (hold_q != HOLD_CAP) begin
          hold_d = hold_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // ---- register stage: FSM, pointer, hold counter, outputs ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      ss_q      <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ss_q      <= ss_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.ss      = ss_q;
  assign bus.busy    = (state_q == ST_OWN);
  assign bus.preempt = preempt_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

  localparam int MAXH = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   check_en = 1'b0;

  mux4_rr_arbiter_if bus ();

  mux4_rr_arbiter #(.MAX_HOLD(MAXH), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // owner == -1 means nobody holds the mux. After any release the owner
  // becomes -1 for exactly one edge, which is the turnaround cycle.
  int         owner = -1;
  int         ptr   = 0;
  int         hold  = 0;
  logic [1:0] exp_ss = 2'd0;
  logic       exp_pre = 1'b0;

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  always @(posedge clk) begin
    logic [3:0] r;
    int         w;
    bit         cut;
    r = bus.req;
    if (!rst_n) begin
      owner = -1; ptr = 0; hold = 0; exp_ss = 2'd0; exp_pre = 1'b0;
    end else begin
      exp_pre = 1'b0;
      if (owner >= 0) begin
        cut = (MAXH != 0) && (hold == MAXH) && ((r & ~(4'b1 << owner)) != 4'b0);
        if (!r[owner] || cut) begin
          exp_pre = r[owner];
          ptr     = (owner + 1) % 4;
          owner   = -1;
        end else if (hold < MAXH || MAXH == 0) begin
          hold = hold + 1;
        end
      end else begin
        w = pick(r, ptr);
        if (w >= 0) begin
          owner  = w;
          exp_ss = 2'(w);
          hold   = 1;
        end
      end
    end
  end

  function automatic logic [3:0] exp_gnt();
    return (owner >= 0) ? (4'b1 << owner) : 4'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (check_en) begin
      chk("model_gnt", 32'(bus.gnt), 32'(exp_gnt()));
      chk("model_ss", 32'(bus.ss), 32'(exp_ss));
      chk("model_busy", 32'(bus.busy), 32'(owner >= 0));
      chk("model_preempt", 32'(bus.preempt), 32'(exp_pre));
      chk("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
      if (bus.gnt != 4'b0)
        chk("gnt_matches_ss", 32'(bus.gnt), 32'(4'b1 << bus.ss));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] order [5];
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    rst_n   = 1'b0;
    bus.req = 4'h0;

    // 1: reset with all requests high
    tick();
    check_en = 1'b1;
    bus.req  = 4'hF;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_gnt", 32'(bus.gnt), 32'h0);
      chk("rst_ss", 32'(bus.ss), 32'h0);
      chk("rst_busy", 32'(bus.busy), 32'h0);
      chk("rst_preempt", 32'(bus.preempt), 32'h0);
    end
    bus.req = 4'h0;
    rst_n   = 1'b1;
    tick();

    // 2: single request
    bus.req = 4'b0100;
    tick();
    chk("single_gnt", 32'(bus.gnt), 32'b0100);
    chk("single_ss", 32'(bus.ss), 32'd2);
    tick();
    bus.req = 4'b0000;
    tick();
    chk("single_turn_gnt", 32'(bus.gnt), 32'h0);
    chk("single_turn_ss", 32'(bus.ss), 32'd2);
    tick();
    chk("single_idle_busy", 32'(bus.busy), 32'h0);

    // 3: round-robin with all requests held, each owner releasing after 2 cycles
    do_reset();
    bus.req = 4'hF;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("rr_owner", 32'(bus.gnt), 32'(4'b1 << order[i]));
      tick();
      bus.req = 4'hF & ~(4'b1 << order[i]);
      tick();
      chk("rr_turn_gnt", 32'(bus.gnt), 32'h0);
      bus.req = 4'hF;
      tick();
    end
    bus.req = 4'h0;
    tick();
    tick();

    // 4: preemption after MAX_HOLD cycles
    do_reset();
    bus.req = 4'b0001;
    tick();
    chk("pre_gnt_c1", 32'(bus.gnt), 32'b0001);
    tick();
    bus.req = 4'b1001;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("pre_hold_gnt", 32'(bus.gnt), 32'b0001);
      chk("pre_hold_pulse", 32'(bus.preempt), 32'h0);
    end
    tick();
    chk("pre_drop_gnt", 32'(bus.gnt), 32'h0);
    chk("pre_drop_pulse", 32'(bus.preempt), 32'h1);
    tick();
    chk("pre_next_gnt", 32'(bus.gnt), 32'b1000);
    chk("pre_next_pulse", 32'(bus.preempt), 32'h0);
    bus.req = 4'h0;
    tick();
    tick();

    // 5: lone hog is never preempted
    bus.req = 4'b0010;
    tick();
    for (int i = 0; i < 20; i++) begin
      chk("hog_gnt", 32'(bus.gnt), 32'b0010);
      chk("hog_pulse", 32'(bus.preempt), 32'h0);
      tick();
    end
    bus.req = 4'h0;
    tick();
    tick();

    // 6: reset while requester 2 owns the mux
    bus.req = 4'b0100;
    tick();
    chk("midrst_owner", 32'(bus.gnt), 32'b0100);
    rst_n = 1'b0;
    tick();
    chk("midrst_gnt", 32'(bus.gnt), 32'h0);
    chk("midrst_ss", 32'(bus.ss), 32'h0);
    rst_n   = 1'b1;
    bus.req = 4'b0110;
    tick();
    chk("midrst_next_gnt", 32'(bus.gnt), 32'b0010);
    chk("midrst_next_ss", 32'(bus.ss), 32'd1);
    bus.req = 4'h0;
    tick();
    tick();

    check_en = 1'b0;
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
